// File: rtl/tpu_pkg.sv
// Shared TPU control-path types and constants.
// Holds the down-counter state encoding and its default datapath width.
package tpu_pkg;

  localparam int DOWN_CTR_DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    CTR_IDLE,
    CTR_PIPE,
    CTR_RUN
  } down_ctr_state_t;

endpackage

// File: rtl/dsp_down_ctr_dec.sv
// Purely combinational decrement-by-one (module dsp_dec).
// The result net carries use_dsp so the subtractor lands in a DSP slice.
module dsp_dec
  import tpu_pkg::*;
#(
  parameter int COUNTER_WIDTH = DOWN_CTR_DEFAULT_WIDTH
) (
  input  logic [COUNTER_WIDTH-1:0] din,
  output logic [COUNTER_WIDTH-1:0] dout
);

  (* use_dsp = "yes" *) logic [COUNTER_WIDTH-1:0] dec_res;

  assign dec_res = din - COUNTER_WIDTH'(1);
  assign dout    = dec_res;

endmodule

// File: rtl/dsp_down_ctr.sv
// Loadable down-counter with one-stage load pipeline and a one-clock done pulse at zero.
// Optional periodic auto-reload build: define DSP_DOWN_CTR_AUTO_RELOAD_EN.
module dsp_down_ctr
  import tpu_pkg::*;
#(
  parameter int COUNTER_WIDTH = DOWN_CTR_DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [COUNTER_WIDTH-1:0] start_val,
  input  logic                     load,
  output logic [COUNTER_WIDTH-1:0] ctr_val,
  output logic                     busy,
  output logic                     zero,
  output logic                     done
);

  down_ctr_state_t          state_q;
  down_ctr_state_t          state_nxt;
  logic [COUNTER_WIDTH-1:0] ctr_q;
  logic [COUNTER_WIDTH-1:0] ctr_nxt;
  logic [COUNTER_WIDTH-1:0] reload_q;
  logic [COUNTER_WIDTH-1:0] reload_nxt;
  logic [COUNTER_WIDTH-1:0] dec_val;
  logic                     done_q;
  logic                     done_nxt;
  logic                     reload_zero;
  logic                     ctr_is_one;

  assign reload_zero = (reload_q == '0);
  assign ctr_is_one  = (ctr_q == COUNTER_WIDTH'(1));

  dsp_dec #(
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_dec (
    .din (ctr_q),
    .dout(dec_val)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CTR_IDLE;
    end else if (enable) begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; load pre-empts everything, including an in-flight count
  always_comb begin
    state_nxt = state_q;
    if (load) begin
      state_nxt = CTR_PIPE;
    end else begin
      case (state_q)
        CTR_PIPE: begin
`ifdef DSP_DOWN_CTR_AUTO_RELOAD_EN
          state_nxt = CTR_RUN;
`else
          state_nxt = reload_zero ? CTR_IDLE : CTR_RUN;
`endif
        end
        CTR_RUN: begin
`ifndef DSP_DOWN_CTR_AUTO_RELOAD_EN
          if (ctr_is_one) begin
            state_nxt = CTR_IDLE;
          end
`endif
        end
        default: state_nxt = state_q;
      endcase
    end
  end

  // Datapath next values driven by the current state
  always_comb begin
    ctr_nxt    = ctr_q;
    reload_nxt = reload_q;
    done_nxt   = 1'b0;
    if (load) begin
      reload_nxt = start_val;
    end else begin
      case (state_q)
        CTR_PIPE: begin
          ctr_nxt  = reload_q;
          done_nxt = reload_zero;
        end
        CTR_RUN: begin
          if (ctr_q != '0) begin
            ctr_nxt  = dec_val;
            done_nxt = ctr_is_one;
          end
`ifdef DSP_DOWN_CTR_AUTO_RELOAD_EN
          else begin
            ctr_nxt  = reload_q;
            done_nxt = reload_zero;
          end
`endif
        end
        default: ctr_nxt = ctr_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr_q    <= '0;
      reload_q <= '0;
    end else if (enable) begin
      ctr_q    <= ctr_nxt;
      reload_q <= reload_nxt;
    end
  end

  // done drops on any edge without enable so a stall can never widen the pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else if (enable) begin
      done_q <= done_nxt;
    end else begin
      done_q <= 1'b0;
    end
  end

  assign ctr_val = ctr_q;
  assign busy    = (state_q != CTR_IDLE);
  assign zero    = (ctr_q == '0);
  assign done    = done_q;

endmodule

// File: tb/tb_dsp_down_ctr.sv
// Self-checking bench for dsp_down_ctr: every-cycle model compare plus directed literal checks.
// Exercises the one-shot build by default, the periodic build when DSP_DOWN_CTR_AUTO_RELOAD_EN is set.
module tb_dsp_down_ctr;

`ifdef DSP_DOWN_CTR_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] start_val;
  logic        load;
  logic [31:0] ctr_val;
  logic        busy;
  logic        zero;
  logic        done;

  int passed = 0;
  int total  = 0;
  bit checking = 1'b0;

  dsp_down_ctr #(.COUNTER_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .start_val(start_val),
    .load     (load),
    .ctr_val  (ctr_val),
    .busy     (busy),
    .zero     (zero),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // Count value k enabled edges after the load edge, from the arithmetic definition
  function automatic longint model_val(input longint start, input longint k);
    longint pos;
    pos = k - 1;
    if (AUTO) pos = pos % (start + 1);
    if (pos > start) return 0;
    return start - pos;
  endfunction

  logic [31:0] m_ctr;
  logic        m_done;
  bit          m_active;
  longint      m_k;
  longint      m_start;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ctr    <= '0;
      m_done   <= 1'b0;
      m_active <= 1'b0;
      m_k      <= 0;
      m_start  <= 0;
    end else if (!enable) begin
      m_done <= 1'b0;
    end else if (load) begin
      m_start  <= longint'(start_val);
      m_k      <= 0;
      m_active <= 1'b1;
      m_done   <= 1'b0;
    end else if (m_active) begin
      m_k    <= m_k + 1;
      m_ctr  <= 32'(model_val(m_start, m_k + 1));
      m_done <= (model_val(m_start, m_k + 1) == 0);
      if (!AUTO && model_val(m_start, m_k + 1) == 0) m_active <= 1'b0;
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (checking && !rst) begin
      chk("model_ctr", ctr_val, m_ctr);
      chk("model_busy", {31'b0, busy}, {31'b0, m_active});
      chk("model_done", {31'b0, done}, {31'b0, m_done});
      chk("model_zero", {31'b0, zero}, {31'b0, (m_ctr == 0)});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [31:0] v);
    load      = 1'b1;
    start_val = v;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic [31:0] c, input logic b, input logic d);
    chk({name, "_ctr"}, ctr_val, c);
    chk({name, "_busy"}, {31'b0, busy}, {31'b0, b});
    chk({name, "_done"}, {31'b0, done}, {31'b0, d});
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; load = 1'b0; start_val = '0;
    #1;
    chk_out("reset", 32'd0, 1'b0, 1'b0);
    chk("reset_zero", {31'b0, zero}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0; enable = 1'b1; checking = 1'b1;
    tick(2);

`ifdef DSP_DOWN_CTR_AUTO_RELOAD_EN
    do_load(32'd3);
    chk_out("ar_e0", 32'd0, 1'b1, 1'b0);
    tick(1);
    chk_out("ar_e1", 32'd3, 1'b1, 1'b0);
    for (int p = 0; p < 3; p++) begin
      for (int v = 2; v >= 0; v--) begin
        tick(1);
        chk_out("ar_seq", 32'(v), 1'b1, (v == 0));
      end
      tick(1);
      chk_out("ar_wrap", 32'd3, 1'b1, 1'b0);
    end
    do_load(32'd0);
    tick(1);
    chk_out("ar_z0", 32'd0, 1'b1, 1'b1);
    tick(1);
    chk_out("ar_z1", 32'd0, 1'b1, 1'b1);
    enable = 1'b0;
    tick(1);
    chk_out("ar_zstall", 32'd0, 1'b1, 1'b0);
    enable = 1'b1;
    tick(2);
`else
    // Basic load of 5
    do_load(32'd5);
    chk_out("l5_e0", 32'd0, 1'b1, 1'b0);
    tick(1);
    chk_out("l5_e1", 32'd5, 1'b1, 1'b0);
    for (int v = 4; v >= 0; v--) begin
      tick(1);
      chk_out("l5_seq", 32'(v), (v != 0), (v == 0));
    end
    tick(1);
    chk_out("l5_after", 32'd0, 1'b0, 1'b0);

    // Zero load
    do_load(32'd0);
    tick(1);
    chk_out("z_e1", 32'd0, 1'b0, 1'b1);
    tick(1);
    chk_out("z_after", 32'd0, 1'b0, 1'b0);

    // Stall mid-count
    do_load(32'd3);
    tick(2);
    chk_out("st_pre", 32'd2, 1'b1, 1'b0);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk_out("st_hold", 32'd2, 1'b1, 1'b0);
    end
    enable = 1'b1;
    tick(1);
    chk_out("st_1", 32'd1, 1'b1, 1'b0);
    tick(1);
    chk_out("st_0", 32'd0, 1'b0, 1'b1);
    tick(1);
    chk_out("st_after", 32'd0, 1'b0, 1'b0);

    // done clears on a disabled edge
    do_load(32'd1);
    tick(2);
    chk_out("dc_pulse", 32'd0, 1'b0, 1'b1);
    enable = 1'b0;
    tick(1);
    chk_out("dc_clear", 32'd0, 1'b0, 1'b0);
    enable = 1'b1;

    // Abort at ctr_val = 1
    do_load(32'd10);
    tick(1);
    chk_out("ab_10", 32'd10, 1'b1, 1'b0);
    tick(9);
    chk_out("ab_1", 32'd1, 1'b1, 1'b0);
    do_load(32'd2);
    chk_out("ab_hold", 32'd1, 1'b1, 1'b0);
    tick(1);
    chk_out("ab_2", 32'd2, 1'b1, 1'b0);
    tick(1);
    chk_out("ab_1b", 32'd1, 1'b1, 1'b0);
    tick(1);
    chk_out("ab_0", 32'd0, 1'b0, 1'b1);
    tick(1);

    // All-ones start value counts down without wrapping
    do_load(32'hFFFF_FFFF);
    tick(1);
    chk_out("ones_e1", 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick(1);
    chk_out("ones_e2", 32'hFFFF_FFFE, 1'b1, 1'b0);
    chk("ones_zero", {31'b0, zero}, 32'd0);
`endif

    // Async reset mid-count at ctr_val = 7
    do_load(32'd9);
    tick(3);
    chk("ar7_ctr", ctr_val, 32'd7);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 32'd0, 1'b0, 1'b0);
    chk("async_zero", {31'b0, zero}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(3);
    chk_out("post_rst", 32'd0, 1'b0, 1'b0);

    checking = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dsp_down_ctr.md
# dsp_down_ctr

Loadable down-counter, the count-down counterpart of the DSP load counter. It loads a start value through a one-stage input pipeline, decrements once per enabled cycle, and emits a one-cycle `done` pulse on reaching zero. It is used by the TPU control path as a terminal-count timer for weight, activation and accumulator transfer bursts, where the up-counter generates addresses.

## Interface
- `COUNTER_WIDTH`, 32: width of `start_val` and `ctr_val`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  clock enable; when low, all state, pipeline and counter registers hold.
- `start_val`  in  COUNTER_WIDTH  unsigned count to load.
- `load`  in  1  load request, sampled only on edges where `enable`=1.
- `ctr_val`  out  COUNTER_WIDTH  current count, registered.
- `busy`  out  1  high whenever state ≠ IDLE.
- `zero`  out  1  combinational `ctr_val == 0`.
- `done`  out  1  registered, one-clock pulse when the count reaches 0.

## Operation
- Internal registers: `state` ∈ {IDLE, PIPE, RUN}; `reload_q` (COUNTER_WIDTH) holding the last loaded value.
- Every transition below happens only on a rising edge with `enable`=1; `done` is the only exception.
- **Any state, `load`=1:**
  - `reload_q` ← `start_val`; `state` → PIPE.
  - `ctr_val` holds; `done` ← 0.
  - `load` has priority over every other event.
- **PIPE:**
  - `ctr_val` ← `reload_q`.
  - If `reload_q`=0: `done` ← 1 and `state` → IDLE (auto-reload build: → RUN).
  - Otherwise `state` → RUN.
- **RUN, `ctr_val`>1:** `ctr_val` ← `ctr_val` − 1.
- **RUN, `ctr_val`=1:** `ctr_val` ← 0; `done` ← 1; `state` → IDLE (auto-reload build: stay RUN).
- **RUN, `ctr_val`=0:** reachable only in the auto-reload build; see Configuration.
- **IDLE:** `ctr_val` holds, at 0 after a completed count.
- **Arithmetic:**
  - Unsigned, modulo 2^COUNTER_WIDTH.
  - The decrement never wraps in RUN, because 0 is never decremented.
  - `start_val` = all-ones is legal and counts 2^W−1 steps.
- **Abort:** a load during PIPE or RUN restarts the sequence with the new value; the aborted count produces no `done`.

## Timing
- Reset values: `state`=IDLE, `ctr_val`=0, `reload_q`=0, `done`=0, `busy`=0, `zero`=1.
- Reset is asynchronous in both assertion and effect on all registers.
- Load latency:
  - `load` sampled at edge E0 → `ctr_val`=`start_val` after E1.
  - E1 is the next enabled edge.
- `ctr_val` reaches 0 after E1 + `start_val` enabled edges.
  - `done` is high for exactly the clock following that edge.
- `done` clearing: `done` clears on the next rising edge regardless of `enable`, so the pulse is always one clock wide.
- `busy`:
  - Rises after E0.
  - Falls together with `done` rising (non-reload build).
- Stalls: `enable` low for N cycles delays all of the above by N cycles; counter and pipeline never advance while stalled.

## Configuration
- Macro: `DSP_DOWN_CTR_AUTO_RELOAD_EN`.
- **Defined (auto-reload build):**
  - From RUN with `ctr_val`=0, the next enabled edge sets `ctr_val` ← `reload_q`, or ← 0 again if `reload_q`=0.
  - The counter runs periodically with period `start_val`+1 enabled cycles, pulsing `done` once per period.
  - `reload_q`=0 gives `done` on every enabled cycle.
  - `busy` stays high until `rst`; a new `load` restarts the sequence.
- **Undefined:** one-shot behaviour as in Operation; the ctr=0 RUN branch is absent.

## Structure
- Add to `tpu_pkg`:
  - `typedef enum logic [1:0] {CTR_IDLE, CTR_PIPE, CTR_RUN} down_ctr_state_t`.
  - Constant `DOWN_CTR_DEFAULT_WIDTH` = 32.
- One sub-module, `dsp_dec`: a purely combinational `COUNTER_WIDTH` decrement-by-one, with its result net tagged `use_dsp = "yes"` so the subtractor maps to a DSP slice.
- The top level holds the FSM, `reload_q`, `ctr_val` and the `done` register.

## Test plan
- **Reset, then load:** release `rst`; `enable`=1; `load`=1 with `start_val`=5 for one edge → `ctr_val`=5 after E1; values 4,3,2,1,0 on the next five edges; `done` high one clock after 0; `busy` falls together with `done` rising.
- **Zero load:** load `start_val`=0 → `ctr_val`=0 after E1, `done` pulse at that point, `busy` back low (non-reload build).
- **Stall:** load 3, then hold `enable`=0 for 4 cycles mid-count → `ctr_val` frozen; total count stretched by exactly 4 cycles; `done` still one clock wide.
- **Abort:** load 10; at `ctr_val`=1, load 2 on the same edge → no `done`; `ctr_val` goes 1 (hold), 2, 1, 0; single `done` pulse.
- **Async reset mid-count:** assert `rst` between edges while `ctr_val`=7 → outputs go immediately to reset values without waiting for a clock edge.
- **Auto-reload build** (`DSP_DOWN_CTR_AUTO_RELOAD_EN` defined): load 3 → sequence 3,2,1,0,3,2,1,0…; `done` every 4 enabled cycles; `busy` stays high.
